// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Used by the fetch stage and its buffer.
package riscv_pkg;

  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] INST_NOP_BUBBLE  = 32'h0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // B-type immediate bits [12:1]; zero for non-branch opcodes
  function automatic logic [11:0] b_imm(
    input logic [31:0] i
  );
    logic [11:0] r;
    r = 12'h0;
    if (i[6:0] == OPC_BRANCH) begin
      r = {i[31], i[7], i[30:25], i[11:8]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Flush wins over push/pop; push on full allowed with pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output fetch_entry_t  entry_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign entry_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// One outstanding imem request, buffered responses, redirect flush.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazard_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [11:0] pcIm_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        out_q, out_d;
  logic        drop_q, drop_d;
  logic        hold_q, hold_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        stale_q, stale_d;

  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          resp;
  logic          out_busy;
  logic          incoming;
  logic [CW:0]   used;
  logic [CW:0]   lim;
  logic          credit_ok;
  logic          issue_new;
  logic          gnt_fire;
  logic          stale_fire;

  assign resp     = imem_rvalid_i && out_q;
  assign out_busy = out_q && !imem_rvalid_i;
  assign incoming = resp && !drop_q;

  assign valid_o  = !empty && !redirect_i && !rst_i;
  assign pop      = valid_o && !hazard_i;
  assign push     = incoming && !redirect_i;

  // buffer slots still free once this cycle's push/pop settle
  assign used      = {1'b0, count} + (CW+1)'(incoming);
  assign lim       = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign credit_ok = (used < lim) && (!full || pop);

  assign issue_new  = start_i && !hold_q && !out_busy && credit_ok;
  assign imem_req_o = !rst_i && (hold_q || issue_new);
  assign imem_addr_o = hold_q ? hold_addr_q : fpc_q;

  assign gnt_fire   = imem_req_o && imem_gnt_i;
  assign stale_fire = gnt_fire && hold_q && stale_q;

  assign push_entry = '{pc: req_pc_q, inst: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .entry_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    fpc_d = fpc_q;
    if (gnt_fire && !(hold_q && stale_q)) begin
      fpc_d = fpc_q + 32'd4;
    end
    if (redirect_i) begin
      fpc_d = redirect_pc_i & ~32'd3;
    end
  end

  always_comb begin
    req_pc_d = gnt_fire ? imem_addr_o : req_pc_q;
    out_d    = out_q;
    if (resp)     out_d = 1'b0;
    if (gnt_fire) out_d = 1'b1;
  end

  // a stale request keeps exactly one response marked for discard
  always_comb begin
    drop_d = drop_q;
    if (resp)       drop_d = 1'b0;
    if (stale_fire) drop_d = 1'b1;
    if (redirect_i && (out_busy || gnt_fire)) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    hold_d      = imem_req_o && !imem_gnt_i;
    hold_addr_d = imem_addr_o;
    stale_d     = hold_d &&
                  ((hold_q && stale_q) || redirect_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc_q       <= RESET_PC;
      req_pc_q    <= RESET_PC;
      out_q       <= 1'b0;
      drop_q      <= 1'b0;
      hold_q      <= 1'b0;
      hold_addr_q <= RESET_PC;
      stale_q     <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      req_pc_q    <= req_pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      stale_q     <= stale_d;
    end
  end

  assign pc_o   = valid_o ? head.pc : fpc_q;
  assign inst_o = valid_o ? head.inst : INST_NOP_BUBBLE;
  assign pcIm_o = b_imm(inst_o);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit with a memory responder
// and an in-order instruction-stream scoreboard.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        hazard_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [11:0] pcIm_o;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .hazard_i      (hazard_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .pcIm_o        (pcIm_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  int          gnt_pct = 100;
  int          max_lat = 0;
  bit          force_rv = 1'b0;

  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr;
  int          mem_wait;

  bit          prev_req = 1'b0;
  bit          prev_gnt = 1'b0;
  logic [31:0] prev_addr;

  logic [31:0] exp_pc = 32'h0;

  bit          last_valid;
  bit          last_req;
  logic [31:0] last_pc;
  logic [31:0] last_inst;
  logic [31:0] last_addr;
  logic [11:0] last_imm;
  logic [31:0] pops [$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  function automatic logic [11:0] ref_imm(input logic [31:0] w);
    logic [11:0] r;
    r = 12'h0;
    if (w[6:0] == 7'b1100011) begin
      r = {w[31], w[7], w[30:25], w[11:8]};
    end
    return r;
  endfunction

  task automatic step(
    input bit          st,
    input bit          hz,
    input bit          rd,
    input logic [31:0] rpc
  );
    bit          rv;
    bit          real_rv;
    bit          g;
    bit          v;
    logic [31:0] a;
    @(negedge clk);
    start_i       = st;
    hazard_i      = hz;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    real_rv       = mem_pending && (mem_wait == 0);
    rv            = real_rv || force_rv;
    imem_rvalid_i = rv;
    imem_rdata_i  = real_rv ? memword(mem_addr) : $urandom;
    #1;
    g = imem_req_o &&
        (int'($urandom_range(99)) < gnt_pct);
    imem_gnt_i = g;
    #1;
    v = valid_o;
    a = imem_addr_o;
    if (v === 1'b1) begin
      checks++;
      if (pc_o !== exp_pc)
        begin errors++; $display("FAIL order pc got %h want %h", pc_o, exp_pc); end
      checks++;
      if (inst_o !== memword(exp_pc))
        begin errors++; $display("FAIL inst got %h want %h", inst_o, memword(exp_pc)); end
      checks++;
      if (pcIm_o !== ref_imm(memword(exp_pc)))
        begin errors++; $display("FAIL pcim got %h want %h", pcIm_o, ref_imm(memword(exp_pc))); end
    end else begin
      checks++;
      if (inst_o !== 32'h0 || pcIm_o !== 12'h0)
        begin errors++; $display("FAIL bubble inst %h imm %h want 0", inst_o, pcIm_o); end
    end
    if (rd) begin
      checks++;
      if (v !== 1'b0)
        begin errors++; $display("FAIL redirect_bubble valid %b want 0", v); end
    end
    if (imem_req_o === 1'b1) begin
      checks++;
      if (mem_pending && !real_rv)
        begin errors++; $display("FAIL one_outstanding req %b want 0", imem_req_o); end
      checks++;
      if (a[1:0] !== 2'b00)
        begin errors++; $display("FAIL addr_align got %h want low bits 0", a); end
    end
    if (prev_req && !prev_gnt) begin
      checks++;
      if (imem_req_o !== 1'b1 || a !== prev_addr)
        begin errors++; $display("FAIL req_stable req %b addr %h want 1 %h", imem_req_o, a, prev_addr); end
    end
    last_valid = v;
    last_req   = imem_req_o;
    last_addr  = a;
    last_pc    = pc_o;
    last_inst  = inst_o;
    last_imm   = pcIm_o;
    if (v && !hz && !rd) pops.push_back(pc_o);
    @(posedge clk);
    if (real_rv) mem_pending = 1'b0;
    else if (mem_pending) mem_wait--;
    if (g) begin
      mem_pending = 1'b1;
      mem_addr    = a;
      mem_wait    = int'($urandom_range(max_lat));
    end
    prev_req = last_req;
    prev_gnt = g;
    prev_addr = a;
    force_rv = 1'b0;
    if (rd) exp_pc = rpc & ~32'd3;
    else if (v && !hz) exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; hazard_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    mem_pending = 1'b0; prev_req = 1'b0; exp_pc = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req_o !== 1'b0)
        begin errors++; $display("FAIL reset_req got %b want 0", imem_req_o); end
      checks++;
      if (valid_o !== 1'b0)
        begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
      checks++;
      if (pc_o !== 32'h0)
        begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
      begin errors++; $display("FAIL first_req req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
    prev_req = 1'b1; prev_gnt = 1'b0; prev_addr = 32'h0;
    gnt_pct = 0;
    force_rv = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b0)
      begin errors++; $display("FAIL stray_rvalid valid %b want 0", last_valid); end
  endtask

  task automatic test_stream();
    int nv;
    gnt_pct = 100; max_lat = 0; nv = 0;
    pops.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (i >= 4 && last_valid) nv++;
    end
    checks++;
    if (pops.size() < 3)
      begin errors++; $display("FAIL stream_pops got %0d want >=3", pops.size()); end
    else begin
      checks++;
      if (pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8)
        begin errors++; $display("FAIL stream_seq got %h %h %h want 0 4 8", pops[0], pops[1], pops[2]); end
    end
    checks++;
    if (nv != 8)
      begin errors++; $display("FAIL stream_rate got %0d want 8", nv); end
  endtask

  task automatic test_stall();
    logic [31:0] h;
    int nv;
    h = 32'h0; nv = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) h = last_pc;
    end
    checks++;
    if (last_req !== 1'b0)
      begin errors++; $display("FAIL stall_req got %b want 0", last_req); end
    checks++;
    if (last_valid !== 1'b1 || last_pc !== h)
      begin errors++; $display("FAIL stall_head valid %b pc %h want 1 %h", last_valid, last_pc, h); end
    gnt_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_valid) nv++;
    end
    checks++;
    if (nv != 2)
      begin errors++; $display("FAIL stall_buffered got %0d want 2", nv); end
    gnt_pct = 100;
  endtask

  task automatic test_redirect_inflight();
    bit found;
    bit got_req;
    bit got_v;
    found = 1'b0; got_req = 1'b0; got_v = 1'b0;
    gnt_pct = 100; max_lat = 3;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_pending && mem_wait > 0) found = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (!found)
      begin errors++; $display("FAIL inflight_wait got 0 want 1"); end
    step(1'b1, 1'b0, 1'b1, 32'h103);
    for (int i = 0; i < 40 && !got_v; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_req && !got_req) begin
        got_req = 1'b1;
        checks++;
        if (last_addr !== 32'h100)
          begin errors++; $display("FAIL inflight_addr got %h want 100", last_addr); end
      end
      if (last_valid) begin
        got_v = 1'b1;
        checks++;
        if (last_pc !== 32'h100)
          begin errors++; $display("FAIL inflight_pc got %h want 100", last_pc); end
      end
    end
    checks++;
    if (!got_v)
      begin errors++; $display("FAIL inflight_timeout got 0 want 1"); end
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    bit got_v;
    found = 1'b0; got_v = 1'b0;
    gnt_pct = 100; max_lat = 2;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_pending && mem_wait == 0) found = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (!found)
      begin errors++; $display("FAIL rv_wait got 0 want 1"); end
    gnt_pct = 0;
    step(1'b0, 1'b0, 1'b1, 32'h300);
    gnt_pct = 100;
    for (int i = 0; i < 40 && !got_v; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_valid) begin
        got_v = 1'b1;
        checks++;
        if (last_pc !== 32'h300)
          begin errors++; $display("FAIL rv_first_pc got %h want 300", last_pc); end
      end
    end
    checks++;
    if (!got_v)
      begin errors++; $display("FAIL rv_timeout got 0 want 1"); end
  endtask

  task automatic test_predecode();
    bit g0;
    bit g1;
    g0 = 1'b0; g1 = 1'b0;
    gnt_pct = 100; max_lat = 1;
    step(1'b1, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 40 && !g1; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_valid && last_pc == 32'h200) begin
        g0 = 1'b1;
        checks++;
        if (last_inst !== 32'hFE000EE3 || last_imm !== 12'hFFE)
          begin errors++; $display("FAIL predec_beq inst %h imm %h want fe000ee3 ffe", last_inst, last_imm); end
      end else if (last_valid && last_pc == 32'h204) begin
        g1 = 1'b1;
        checks++;
        if (last_imm !== 12'h0)
          begin errors++; $display("FAIL predec_addi imm %h want 0", last_imm); end
      end
    end
    checks++;
    if (!(g0 && g1))
      begin errors++; $display("FAIL predec_seen got %b%b want 11", g0, g1); end
  endtask

  task automatic test_random();
    bit got_v;
    got_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      gnt_pct = int'($urandom_range(100, 30));
      max_lat = int'($urandom_range(3));
      for (int i = 0; i < 50; i++) begin
        step(($urandom % 8) != 0, ($urandom % 4) == 0,
             ($urandom % 16) == 0, $urandom & 32'hFFF);
      end
    end
    gnt_pct = 100;
    for (int i = 0; i < 40 && !got_v; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_valid) got_v = 1'b1;
    end
    checks++;
    if (!got_v)
      begin errors++; $display("FAIL random_progress got 0 want 1"); end
  endtask

  task automatic test_reset_midop();
    bit got_v;
    got_v = 1'b0;
    gnt_pct = 100; max_lat = 2;
    repeat (7) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 32'h0)
      begin errors++; $display("FAIL midrst v %b req %b pc %h want 0 0 0", valid_o, imem_req_o, pc_o); end
    rst_i = 1'b0;
    mem_pending = 1'b0; prev_req = 1'b0; exp_pc = 32'h0;
    force_rv = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (last_valid !== 1'b0)
      begin errors++; $display("FAIL midrst_stray valid %b want 0", last_valid); end
    for (int i = 0; i < 20 && !got_v; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_valid) begin
        got_v = 1'b1;
        checks++;
        if (last_pc !== 32'h0)
          begin errors++; $display("FAIL midrst_pc got %h want 0", last_pc); end
      end
    end
    checks++;
    if (!got_v)
      begin errors++; $display("FAIL midrst_timeout got 0 want 1"); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i][0]) mem[i][6:0] = 7'b1100011;
    end
    mem[128] = 32'hFE000EE3;
    mem[129] = 32'h00000013;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_predecode();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
